tds_channel_packet_builder: RTL and testbench

Sits directly downstream of the strip/pad decoder's channel FIFO, in the clk_readout domain. It drains 120-bit channel words and frames them into 16-bit packets: header, length, payload, checksum and trailer. Output uses a valid/ready stream toward the readout link arbiter. A packet starts when enough events are queued or a timeout expires with data pending.

---
 rtl/tds_channel_packet_builder.sv | 188 ++++++++++++++++++
 tb/tb_tds_channel_packet_builder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tds_channel_packet_builder.sv
// rtl/tds_channel_packet_builder.sv - frames 120-bit channel FIFO words into 16-bit header/length/payload/checksum/trailer packets
//
// Ports:
//   clk_readout          readout clock
//   reset                asynchronous active-high reset
//   enable               allows new packets to start (a packet in flight always completes)
//   channel_data         channel FIFO dout, valid the cycle after channel_data_read
//   channel_fifo_empty   channel FIFO empty flag
//   channel_data_counter channel FIFO occupancy
//   channel_data_read    channel FIFO rd_en, one pulse per event
//   out_data/out_valid/out_ready/out_last  packet word stream
//   busy                 high whenever not IDLE
//   packet_seq           sequence number of the last completed packet
module tds_channel_packet_builder #(
    parameter logic [4:0] CHANNEL_ID     = 5'd0,
    parameter int         MIN_EVENTS     = 8,
    parameter int         MAX_EVENTS     = 64,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_readout,
    input  logic         reset,
    input  logic         enable,
    input  logic [119:0] channel_data,
    input  logic         channel_fifo_empty,
    input  logic [9:0]   channel_data_counter,
    output logic         channel_data_read,
    output logic [15:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic [7:0]   packet_seq
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]    MIN_W = 10'(MIN_EVENTS);
    localparam logic [9:0]    MAX_W = 10'(MAX_EVENTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LENGTH,
        S_FETCH,
        S_WAIT,
        S_PAYLOAD,
        S_CKSUM,
        S_TRAILER
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [9:0]    nev_q, nev_d;
    logic [9:0]    rem_q, rem_d;
    logic [127:0]  sreg_q, sreg_d;
    logic [2:0]    widx_q, widx_d;
    logic [15:0]   cksum_q, cksum_d;
    logic [7:0]    seq_q, seq_d;

    logic          accept;
    logic          start;

    assign accept = out_valid & out_ready;

    // Either enough events are queued, or data has been waiting the full timeout.
    assign start = enable &&
                   ((channel_data_counter >= MIN_W) ||
                    ((tcnt_q == T_MAX) && !channel_fifo_empty));

    always_ff @(posedge clk_readout or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            nev_q   <= '0;
            rem_q   <= '0;
            sreg_q  <= '0;
            widx_q  <= '0;
            cksum_q <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            nev_q   <= nev_d;
            rem_q   <= rem_d;
            sreg_q  <= sreg_d;
            widx_q  <= widx_d;
            cksum_q <= cksum_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        tcnt_d            = tcnt_q;
        nev_d             = nev_q;
        rem_d             = rem_q;
        sreg_d            = sreg_q;
        widx_d            = widx_q;
        cksum_d           = cksum_q;
        seq_d             = seq_q;
        out_valid         = 1'b0;
        out_data          = 16'h0000;
        out_last          = 1'b0;
        channel_data_read = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Counter keeps running (and saturates) even while enable is low,
                // so a stale event starts a packet as soon as enable returns.
                if (channel_fifo_empty) begin
                    tcnt_d = '0;
                end else if (tcnt_q != T_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (start) begin
                    nev_d   = (channel_data_counter > MAX_W) ? MAX_W : channel_data_counter;
                    rem_d   = (channel_data_counter > MAX_W) ? MAX_W : channel_data_counter;
                    cksum_d = '0;
                    tcnt_d  = '0;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = {8'hA5, 3'b000, CHANNEL_ID};
                if (accept) begin
                    cksum_d = cksum_q ^ out_data;
                    state_d = S_LENGTH;
                end
            end
            S_LENGTH: begin
                out_valid = 1'b1;
                out_data  = {6'b000000, nev_q};
                if (accept) begin
                    cksum_d = cksum_q ^ out_data;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Sole reader of the FIFO and N never exceeds the occupancy seen
                // at start, so no empty re-check is needed here.
                channel_data_read = 1'b1;
                state_d           = S_WAIT;
            end
            S_WAIT: begin
                sreg_d  = {8'h00, channel_data};
                widx_d  = 3'd0;
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = sreg_q[127:112];
                if (accept) begin
                    cksum_d = cksum_q ^ out_data;
                    sreg_d  = {sreg_q[111:0], 16'h0000};
                    widx_d  = widx_q + 3'd1;
                    if (widx_q == 3'd7) begin
                        rem_d   = rem_q - 10'd1;
                        state_d = (rem_q != 10'd1) ? S_FETCH : S_CKSUM;
                    end
                end
            end
            S_CKSUM: begin
                out_valid = 1'b1;
                out_data  = cksum_q;
                if (accept) begin
                    state_d = S_TRAILER;
                end
            end
            S_TRAILER: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = {8'h5A, seq_q + 8'd1};
                if (accept) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign packet_seq = seq_q;

endmodule

// File: tb/tb_tds_channel_packet_builder.sv
// tb/tb_tds_channel_packet_builder.sv - self-checking bench for tds_channel_packet_builder
module tb_tds_channel_packet_builder;

    logic         clk_readout = 1'b0;
    logic         reset;
    logic         enable;
    logic [119:0] channel_data;
    logic         channel_fifo_empty;
    logic [9:0]   channel_data_counter;
    logic         channel_data_read;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [7:0]   packet_seq;

    int checks = 0;
    int errors = 0;

    logic [119:0] fq[$];    // channel FIFO contents
    logic [119:0] mq[$];    // events not yet checked against output
    logic [16:0]  cap[$];   // accepted {out_last, out_data}
    int           ev_ctr  = 0;
    int           rd_seen = 0;
    bit           rnd_mode = 1'b0;
    logic         stall_prev = 1'b0;
    logic [16:0]  prev_w = '0;

    typedef struct {
        int          n_ev;
        bit          rnd;
        int          exp_lat;
        logic [15:0] exp_len;
        logic [15:0] exp_trl;
    } vec_t;

    vec_t vecs[5];

    tds_channel_packet_builder #(
        .CHANNEL_ID    (5'd3),
        .MIN_EVENTS    (8),
        .MAX_EVENTS    (64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_readout         (clk_readout),
        .reset               (reset),
        .enable              (enable),
        .channel_data        (channel_data),
        .channel_fifo_empty  (channel_fifo_empty),
        .channel_data_counter(channel_data_counter),
        .channel_data_read   (channel_data_read),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_last            (out_last),
        .busy                (busy),
        .packet_seq          (packet_seq)
    );

    always #5 clk_readout = ~clk_readout;

    // FIFO read side, output capture and stall-stability check
    always @(posedge clk_readout) begin
        if (!reset) begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || {out_last, out_data} !== prev_w) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b word=%05h, required valid=1 word=%05h",
                             out_valid, {out_last, out_data}, prev_w);
                end
            end
            stall_prev <= out_valid && !out_ready;
            prev_w     <= {out_last, out_data};
            if (out_valid && out_ready) cap.push_back({out_last, out_data});
            if (channel_data_read && fq.size() > 0) begin
                channel_data <= fq.pop_front();
                rd_seen++;
            end
        end else begin
            stall_prev <= 1'b0;
        end
    end

    // FIFO flags and out_ready are driven away from the active edge
    always @(negedge clk_readout) begin
        channel_data_counter = 10'(fq.size());
        channel_fifo_empty   = (fq.size() == 0);
        out_ready            = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [119:0] make_event(int e);
        logic [119:0] d;
        for (int b = 0; b < 15; b++) d[b*8 +: 8] = 8'((e * 7 + b * 13 + 5) & 255);
        return d;
    endfunction

    function automatic bit has_last();
        foreach (cap[i]) if (cap[i][16]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_events(input int n);
        @(posedge clk_readout);
        #2;
        for (int i = 0; i < n; i++) begin
            logic [119:0] d;
            d = make_event(ev_ctr);
            ev_ctr++;
            fq.push_back(d);
            mq.push_back(d);
        end
    endtask

    task automatic check_packet(input string name, input int n,
                                input logic [15:0] exp_len, input logic [15:0] exp_trl);
        int          wc;
        logic [15:0] ew[$];
        logic [15:0] x;
        logic [127:0] s;
        int          idx;
        bit          done;
        wc = 0;
        while (!has_last() && wc < 20000) begin
            @(negedge clk_readout);
            wc++;
        end
        if (!has_last()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no trailer after %0d cycles, required trailer", name, wc);
            cap.delete();
            return;
        end
        ew.push_back(16'hA503);
        ew.push_back(exp_len);
        for (int e = 0; e < n; e++) begin
            s = {8'h00, mq.pop_front()};
            for (int k = 0; k < 8; k++) ew.push_back(s[127 - 16*k -: 16]);
        end
        x = 16'h0000;
        foreach (ew[i]) x ^= ew[i];
        ew.push_back(x);
        ew.push_back(exp_trl);
        idx  = 0;
        done = 1'b0;
        while (!done) begin
            logic [16:0] w;
            w = cap.pop_front();
            done = w[16];
            if (idx < ew.size())
                chk($sformatf("%s_word%0d", name, idx), {15'd0, w},
                    {15'd0, (idx == ew.size() - 1), ew[idx]});
            idx++;
        end
        chk($sformatf("%s_wordcount", name), idx, ew.size());
        chk($sformatf("%s_packet_seq", name), {24'd0, packet_seq}, {24'd0, exp_trl[7:0]});
    endtask

    initial begin
        int lat;
        logic [7:0] seq_exp;

        vecs[0] = '{n_ev: 1,  rnd: 1'b0, exp_lat: 16, exp_len: 16'h0001, exp_trl: 16'h5A01};
        vecs[1] = '{n_ev: 8,  rnd: 1'b0, exp_lat: 1,  exp_len: 16'h0008, exp_trl: 16'h5A02};
        vecs[2] = '{n_ev: 3,  rnd: 1'b1, exp_lat: 16, exp_len: 16'h0003, exp_trl: 16'h5A03};
        vecs[3] = '{n_ev: 3,  rnd: 1'b0, exp_lat: 16, exp_len: 16'h0003, exp_trl: 16'h5A04};
        vecs[4] = '{n_ev: 12, rnd: 1'b1, exp_lat: 1,  exp_len: 16'h000C, exp_trl: 16'h5A05};

        reset        = 1'b1;
        enable       = 1'b1;
        channel_data = '0;
        repeat (3) @(posedge clk_readout);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_read", {31'd0, channel_data_read}, 32'd0);
        chk("rst_packet_seq", {24'd0, packet_seq}, 32'd0);
        @(negedge clk_readout);
        reset = 1'b0;

        // Reset in the middle of the third event's payload drops the packet
        push_events(3);
        lat = 0;
        while (rd_seen < 3 && lat < 500) begin
            @(negedge clk_readout);
            lat++;
        end
        @(negedge clk_readout);
        chk("mid_payload_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data", {16'd0, out_data}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk_readout);
        reset = 1'b0;
        chk("async_rst_seq", {24'd0, packet_seq}, 32'd0);
        mq.delete();
        cap.delete();
        repeat (2) @(negedge clk_readout);

        // Table-driven packets
        for (int v = 0; v < 5; v++) begin
            rnd_mode = vecs[v].rnd;
            push_events(vecs[v].n_ev);
            lat = 0;
            do begin
                @(posedge clk_readout);
                #1;
                lat++;
            end while (!out_valid && lat < 200);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            check_packet($sformatf("vec%0d", v), vecs[v].n_ev, vecs[v].exp_len, vecs[v].exp_trl);
            rnd_mode = 1'b0;
            @(negedge clk_readout);
        end

        // 70 events queued while disabled: split into 64 + 6
        @(negedge clk_readout);
        enable = 1'b0;
        push_events(70);
        repeat (40) @(negedge clk_readout);
        chk("disabled_busy", {31'd0, busy}, 32'd0);
        chk("disabled_valid", {31'd0, out_valid}, 32'd0);
        enable = 1'b1;
        @(posedge clk_readout);
        #1;
        chk("enable_start_busy", {31'd0, busy}, 32'd1);
        repeat (100) @(negedge clk_readout);
        enable = 1'b0;
        repeat (50) @(negedge clk_readout);
        chk("enable_low_midpacket_busy", {31'd0, busy}, 32'd1);
        enable = 1'b1;
        check_packet("max64", 64, 16'h0040, 16'h5A06);
        check_packet("rem6", 6, 16'h0006, 16'h5A07);

        // Sequence number wrap over 256 single-event packets
        seq_exp = 8'h07;
        for (int p = 0; p < 256; p++) begin
            push_events(1);
            seq_exp = seq_exp + 8'd1;
            check_packet("wrap", 1, 16'h0001, {8'h5A, seq_exp});
        end
        chk("wrap_final_seq", {24'd0, packet_seq}, 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
